// File: rtl/instr_fetch_queue_pkg.sv
// Shared types for the instruction fetch front end: FSM states, FIFO entry
// layout and the PC step used for sequential fetch.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_INCREMENT = 32'h4;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Bus bundle for the fetch queue: instruction memory request/ack, redirect
// from execute and the valid/ready decode side. "master" is the fetch unit.
interface instr_fetch_queue_if #(parameter int DEPTH = 4) ();

  localparam int CW = $clog2(DEPTH + 1);

  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic [31:0]   out_pc_plus4;
  logic [CW-1:0] count;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect, redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr, out_pc, out_pc_plus4, count
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect, redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr, out_pc, out_pc_plus4, count
  );

endinterface

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries. Flush wins over
// push and pop so a redirect always leaves the queue empty.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Entry storage; contents are only meaningful while count covers them.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: owns the fetch PC, keeps one memory request in flight,
// buffers returned words and hands them to decode. A redirect flushes the
// queue; a request already on the bus is then drained and its data dropped.
module instr_fetch_queue
  import riscv_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 reset,
  instr_fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = CW + 1;
  localparam logic [FW-1:0] DEPTH_W = FW'(DEPTH);

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   addr_q;
  logic [31:0]   redirect_target;
  logic          push;
  logic          pop;
  logic [FW-1:0] fill_after;
  fetch_entry_t  push_data;
  fetch_entry_t  head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  assign redirect_target = {bus.redirect_pc[31:2], 2'b00};
  assign pop        = !empty && bus.out_ready && !bus.redirect;
  assign push       = (state == WAIT) && bus.imem_ack && !bus.redirect;
  assign push_data  = '{pc: addr_q, instr: bus.imem_rdata};
  assign fill_after = {1'b0, count} + {{CW{1'b0}}, 1'b1} - {{CW{1'b0}}, pop};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.redirect),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Request FSM: issues addresses, tracks whether in-flight data is kept, and
  // only starts a request when an ack is guaranteed to find a free slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (bus.redirect) begin
            fetch_pc <= redirect_target;
            addr_q   <= redirect_target;
            state    <= WAIT;
          end else if (!full) begin
            addr_q <= fetch_pc;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (bus.redirect) begin
            fetch_pc <= redirect_target;
            if (bus.imem_ack) begin
              addr_q <= redirect_target;
            end else begin
              state <= DISCARD;
            end
          end else if (bus.imem_ack) begin
            fetch_pc <= addr_q + PC_INCREMENT;
            if (fill_after < DEPTH_W) begin
              addr_q <= addr_q + PC_INCREMENT;
            end else begin
              state <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (bus.redirect) begin
            fetch_pc <= redirect_target;
            if (bus.imem_ack) begin
              addr_q <= redirect_target;
              state  <= WAIT;
            end
          end else if (bus.imem_ack) begin
            addr_q <= fetch_pc;
            state  <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.imem_req     = (state != IDLE);
  assign bus.imem_addr    = addr_q;
  assign bus.out_valid    = !empty;
  assign bus.out_instr    = empty ? 32'h0 : head.instr;
  assign bus.out_pc       = empty ? 32'h0 : head.pc;
  assign bus.out_pc_plus4 = empty ? 32'h0 : head.pc + PC_INCREMENT;
  assign bus.count        = count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Testbench for instr_fetch_queue: a reactive memory with configurable latency
// and a queue-based reference model of the fetched instruction stream.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic reset;

  instr_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  ent_t        exp_q[$];
  logic [31:0] req_log[$];
  logic [31:0] model_next_pc;
  bit          model_stale;
  bit          mem_busy;
  int          mem_wait;
  logic [31:0] mem_addr;
  bit          lat_rand;
  int          lat_fixed;
  int          lat_max;
  bit          saw_new;
  int          pops;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F00;
  endfunction

  // One clock cycle: memory answers, model is compared, then the edge is taken.
  task automatic tick();
    bit          ack;
    ent_t        e;
    logic [2:0]  exp_cnt;
    logic [31:0] exp_p4;
    saw_new = 0;
    if (bus.imem_req && !mem_busy) begin
      mem_busy = 1;
      mem_addr = bus.imem_addr;
      mem_wait = lat_rand ? int'($urandom_range(lat_max, 0)) : lat_fixed;
      saw_new  = 1;
      req_log.push_back(bus.imem_addr);
    end else if (mem_busy) begin
      n_vec++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== mem_addr) begin
        n_err++;
        $display("[TB] FAIL held_request: req=%b addr=%h, required req=1 addr=%h", bus.imem_req, bus.imem_addr, mem_addr);
      end
    end
    ack = mem_busy && (mem_wait == 0);
    bus.imem_ack   = ack;
    bus.imem_rdata = ack ? mem_word(mem_addr) : $urandom();
    #1;
    exp_cnt = 3'(exp_q.size());
    n_vec++;
    if (bus.count !== exp_cnt) begin
      n_err++;
      $display("[TB] FAIL count: got %0d, required %0d", bus.count, exp_cnt);
    end
    n_vec++;
    if (bus.out_valid !== (exp_q.size() != 0)) begin
      n_err++;
      $display("[TB] FAIL out_valid: got %b, required %b", bus.out_valid, exp_q.size() != 0);
    end
    if (exp_q.size() != 0) begin
      exp_p4 = exp_q[0].pc + 32'h4;
      n_vec++;
      if (bus.out_pc !== exp_q[0].pc || bus.out_instr !== exp_q[0].instr || bus.out_pc_plus4 !== exp_p4) begin
        n_err++;
        $display("[TB] FAIL head: got pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                 bus.out_pc, bus.out_instr, bus.out_pc_plus4, exp_q[0].pc, exp_q[0].instr, exp_p4);
      end
    end
    if (saw_new) begin
      n_vec++;
      if (bus.imem_addr !== model_next_pc || exp_q.size() >= DEPTH) begin
        n_err++;
        $display("[TB] FAIL new_request: addr=%h with %0d queued, required addr=%h with fewer than %0d queued",
                 bus.imem_addr, exp_q.size(), model_next_pc, DEPTH);
      end
    end
    if (bus.redirect) begin
      exp_q.delete();
      model_next_pc = {bus.redirect_pc[31:2], 2'b00};
      model_stale   = mem_busy && !ack;
    end else begin
      if (bus.out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        pops++;
      end
      if (ack) begin
        if (model_stale) begin
          model_stale = 0;
        end else begin
          e.pc    = mem_addr;
          e.instr = mem_word(mem_addr);
          exp_q.push_back(e);
          model_next_pc = mem_addr + 32'h4;
        end
      end
    end
    @(posedge clk);
    if (ack) mem_busy = 0;
    else if (mem_busy) mem_wait--;
    @(negedge clk);
  endtask

  task automatic model_clear();
    mem_busy = 0;
    exp_q.delete();
    req_log.delete();
    model_next_pc = 32'h0;
    model_stale   = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready = 1'b0;
    lat_rand = 0;
    lat_fixed = 0;
    lat_max = 0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
      n_err++;
      $display("[TB] FAIL reset_ctrl: req=%b valid=%b count=%0d, required 0 0 0", bus.imem_req, bus.out_valid, bus.count);
    end
    n_vec++;
    if (bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0 || bus.out_pc_plus4 !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL reset_data: pc=%h instr=%h pc4=%h, required all zero", bus.out_pc, bus.out_instr, bus.out_pc_plus4);
    end
    apply_reset();
    n_vec++;
    if (bus.imem_req !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL idle_after_reset: req=%b, required 0", bus.imem_req);
    end
    tick();
    n_vec++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL first_request: req=%b addr=%h, required 1 00000000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    bus.out_ready = 1'b1;
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL early_valid: got %b, required 0", bus.out_valid);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * i) || bus.count !== 3'd1) begin
        n_err++;
        $display("[TB] FAIL stream_%0d: valid=%b pc=%h count=%0d, required 1 %h 1", i, bus.out_valid, bus.out_pc, bus.count, 32'(4 * i));
      end
      tick();
    end
  endtask

  task automatic test_fill();
    apply_reset();
    repeat (7) tick();
    n_vec++;
    if (bus.count !== 3'd4 || bus.imem_req !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL fill_stop: count=%0d req=%b, required 4 0", bus.count, bus.imem_req);
    end
    req_log.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (bus.out_pc !== 32'(4 * i)) begin
        n_err++;
        $display("[TB] FAIL drain_%0d: pc=%h, required %h", i, bus.out_pc, 32'(4 * i));
      end
      tick();
    end
    n_vec++;
    if (req_log.size() == 0 || req_log[0] !== 32'h10) begin
      n_err++;
      $display("[TB] FAIL resume: %0d requests seen, first=%h, required first 00000010", req_log.size(), (req_log.size() != 0) ? req_log[0] : 32'hx);
    end
  endtask

  task automatic test_redirect_latency();
    int guard;
    apply_reset();
    lat_fixed = 2;
    bus.out_ready = 1'b1;
    guard = 0;
    while (!(req_log.size() != 0 && req_log[$] == 32'h8) && guard < 40) begin
      tick();
      guard++;
    end
    n_vec++;
    if (guard >= 40) begin
      n_err++;
      $display("[TB] FAIL wait_req8: no request at 00000008 within 40 cycles");
    end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h103;
    req_log.delete();
    tick();
    bus.redirect = 1'b0;
    n_vec++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin
      n_err++;
      $display("[TB] FAIL old_addr_held: req=%b addr=%h, required 1 00000008", bus.imem_req, bus.imem_addr);
    end
    guard = 0;
    while (!bus.out_valid && guard < 40) begin
      tick();
      guard++;
    end
    n_vec++;
    if (req_log.size() == 0 || req_log[0] !== 32'h100) begin
      n_err++;
      $display("[TB] FAIL redirect_req: first new request=%h, required 00000100", (req_log.size() != 0) ? req_log[0] : 32'hx);
    end
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100) begin
      n_err++;
      $display("[TB] FAIL redirect_out: valid=%b pc=%h, required 1 00000100", bus.out_valid, bus.out_pc);
    end
  endtask

  task automatic test_redirect_ack_pop();
    logic [31:0] exp_pc;
    int          seen;
    apply_reset();
    repeat (3) tick();
    n_vec++;
    if (bus.count !== 3'd2 || bus.imem_req !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL setup_count2: count=%0d req=%b, required 2 1", bus.count, bus.imem_req);
    end
    bus.out_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    tick();
    bus.redirect = 1'b0;
    n_vec++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL flush: count=%0d valid=%b, required 0 0", bus.count, bus.out_valid);
    end
    exp_pc = 32'h200;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid) begin
        n_vec++;
        if (bus.out_pc !== exp_pc) begin
          n_err++;
          $display("[TB] FAIL new_stream: pc=%h, required %h", bus.out_pc, exp_pc);
        end
        exp_pc = exp_pc + 32'h4;
        seen++;
      end
      tick();
    end
    n_vec++;
    if (seen < 8) begin
      n_err++;
      $display("[TB] FAIL new_stream_rate: %0d entries in 12 cycles, required at least 8", seen);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc[3];
    logic [31:0] exp_p4[3];
    int          idx;
    exp_pc[0] = 32'hFFFF_FFF8; exp_p4[0] = 32'hFFFF_FFFC;
    exp_pc[1] = 32'hFFFF_FFFC; exp_p4[1] = 32'h0000_0000;
    exp_pc[2] = 32'h0000_0000; exp_p4[2] = 32'h0000_0004;
    apply_reset();
    bus.out_ready = 1'b1;
    repeat (3) tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF9;
    tick();
    bus.redirect = 1'b0;
    idx = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid && idx < 3) begin
        n_vec++;
        if (bus.out_pc !== exp_pc[idx] || bus.out_pc_plus4 !== exp_p4[idx]) begin
          n_err++;
          $display("[TB] FAIL wrap_%0d: pc=%h pc4=%h, required %h %h", idx, bus.out_pc, bus.out_pc_plus4, exp_pc[idx], exp_p4[idx]);
        end
        idx++;
      end
      tick();
    end
    n_vec++;
    if (idx != 3) begin
      n_err++;
      $display("[TB] FAIL wrap_count: %0d entries, required 3", idx);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    repeat (4) tick();
    n_vec++;
    if (bus.count !== 3'd3 || bus.imem_req !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL setup_count3: count=%0d req=%b, required 3 1", bus.count, bus.imem_req);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
      n_err++;
      $display("[TB] FAIL async_reset: req=%b valid=%b count=%0d, required 0 0 0", bus.imem_req, bus.out_valid, bus.count);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) tick();
    n_vec++;
    if (req_log.size() == 0 || req_log[0] !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL restart_pc: first request=%h, required 00000000", (req_log.size() != 0) ? req_log[0] : 32'hx);
    end
  endtask

  task automatic test_random();
    apply_reset();
    lat_rand = 1;
    lat_max = 3;
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.out_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(15, 0) == 0) begin
        bus.redirect = 1'b1;
        bus.redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom();
      end else begin
        bus.redirect = 1'b0;
      end
      tick();
    end
    bus.redirect = 1'b0;
    n_vec++;
    if (pops < 200) begin
      n_err++;
      $display("[TB] FAIL progress: %0d entries delivered, required at least 200", pops);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_redirect_latency();
    test_redirect_ack_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
